// File: rtl/ue_pkg.sv
// Shared definitions for the runner game: obstacle column codes, generator
// FSM states and the LFSR feedback taps.
package ue_pkg;

    localparam logic [1:0] OBS_NONE = 2'b00;
    localparam logic [1:0] OBS_LOW  = 2'b01;
    localparam logic [1:0] OBS_HIGH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } gen_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10 of a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/map_generator_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0; steps only on advance.
module lfsr16
    import ue_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = ^(state & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (advance) begin
            // the all-zero state is a lock-up point, so reseed instead
            if (state == 16'h0000) state <= SEED;
            else                   state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/map_generator.sv
// Scrolling obstacle map: shifts a new 2-bit column in every TICK_DIV cycles while
// running, with a guaranteed run of empty columns after every obstacle.
module map_generator
    import ue_pkg::*;
#(
    parameter int          TICK_DIV  = 25_000_000,
    parameter int          MIN_GAP   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_dead,
    output logic [15:0] map,
    output logic        tick,
    output logic        running,
    output logic [15:0] cols_passed
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int GAP_W = $clog2(MIN_GAP + 2);

    gen_state_e       state;
    logic [DIV_W-1:0] divider;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_next;
    logic [1:0]       new_col;
    logic [15:0]      lfsr_state;
    logic             div_last;
    logic             step;
    logic             advance;

    assign div_last = (divider == DIV_W'(TICK_DIV - 1));
    // a tick is taken only when neither abort nor death lands on the same edge
    assign step     = (state == ST_RUN) && start && !is_dead && div_last;
    assign advance  = (state == ST_IDLE) || step;
    assign running  = (state == ST_RUN);

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(advance),
        .state  (lfsr_state)
    );

    always_comb begin
        new_col  = OBS_NONE;
        gap_next = gap_cnt;
        if (gap_cnt < GAP_W'(MIN_GAP)) begin
            gap_next = gap_cnt + 1'b1;
        end else begin
            if (lfsr_state[1:0] != 2'b11) new_col = lfsr_state[1:0];
            if (new_col != OBS_NONE)      gap_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            map         <= '0;
            tick        <= 1'b0;
            cols_passed <= '0;
            divider     <= '0;
            gap_cnt     <= '0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    map         <= '0;
                    cols_passed <= '0;
                    divider     <= '0;
                    gap_cnt     <= '0;
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!start) begin
                        state       <= ST_IDLE;
                        map         <= '0;
                        cols_passed <= '0;
                        divider     <= '0;
                        gap_cnt     <= '0;
                    end else if (is_dead) begin
                        state <= ST_DEAD;
                    end else if (div_last) begin
                        divider <= '0;
                        map     <= {map[13:0], new_col};
                        tick    <= 1'b1;
                        gap_cnt <= gap_next;
                        if (cols_passed != 16'hFFFF) cols_passed <= cols_passed + 16'd1;
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (!start) begin
                        state       <= ST_IDLE;
                        map         <= '0;
                        cols_passed <= '0;
                        divider     <= '0;
                        gap_cnt     <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_generator.sv
// Randomized bench for map_generator against a game-level reference model.
module tb_map_generator;

    localparam int          TD   = 4;
    localparam int          MG   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_dead = 1'b0;
    logic [15:0] map;
    logic        tick;
    logic        running;
    logic [15:0] cols_passed;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 run, 2 dead
    int          m_st;
    logic [15:0] m_lfsr;
    logic [15:0] m_map;
    logic        m_tick;
    logic [15:0] m_cols;
    int          m_run;
    int          m_since;

    map_generator #(.TICK_DIV(TD), .MIN_GAP(MG), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_dead    (is_dead),
        .map        (map),
        .tick       (tick),
        .running    (running),
        .cols_passed(cols_passed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic model_update(input logic r, input logic s, input logic d);
        logic [1:0] col;
        m_tick = 1'b0;
        if (!r) begin
            m_st = 0; m_map = '0; m_cols = '0; m_run = 0; m_since = 0; m_lfsr = SEED;
            return;
        end
        if (m_st == 0) begin
            m_lfsr = lfsr_next(m_lfsr);
            if (s) begin m_st = 1; m_run = 0; m_since = 0; end
        end else if (!s) begin
            m_st = 0; m_map = '0; m_cols = '0;
        end else if (m_st == 1 && d) begin
            m_st = 2;
        end else if (m_st == 1) begin
            m_run++;
            if (m_run % TD == 0) begin
                if (m_since < MG)               col = 2'b00;
                else if (m_lfsr[1:0] == 2'b11)  col = 2'b00;
                else                            col = m_lfsr[1:0];
                if (col != 2'b00) m_since = 0; else m_since++;
                m_map  = {m_map[13:0], col};
                m_tick = 1'b1;
                m_cols = (m_cols == 16'hFFFF) ? 16'hFFFF : m_cols + 16'd1;
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
    endtask

    task automatic clk_step(input logic r, input logic s, input logic d);
        @(negedge clk);
        rst_n = r; start = s; is_dead = d;
        @(posedge clk);
        model_update(r, s, d);
        #1;
    endtask

    task automatic test_reset();
        clk_step(1'b0, 1'b1, 1'($urandom % 2));
        clk_step(1'b0, 1'b1, 1'($urandom % 2));
        checks++; if (map !== 16'h0000) begin errors++; $display("FAIL reset_map got=%h exp=0000", map); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (cols_passed !== 16'h0000) begin errors++; $display("FAIL reset_cols got=%h exp=0000", cols_passed); end
        checks++; if (dut.u_lfsr.state !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.u_lfsr.state); end
    endtask

    task automatic test_scroll_timing();
        clk_step(1'b0, 1'b1, 1'b0);
        clk_step(1'b1, 1'b1, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL scroll_enter_run got=%b exp=1", running); end
        for (int k = 1; k <= 12; k++) begin
            clk_step(1'b1, 1'b1, 1'b0);
            checks++; if (tick !== ((k % 4) == 0)) begin errors++; $display("FAIL scroll_tick cyc=%0d got=%b exp=%b", k, tick, (k % 4) == 0); end
            checks++; if (map !== m_map) begin errors++; $display("FAIL scroll_map cyc=%0d got=%h exp=%h", k, map, m_map); end
            if (k == 4 || k == 8) begin
                checks++; if (map[1:0] !== 2'b00) begin errors++; $display("FAIL scroll_first_cols cyc=%0d got=%b exp=00", k, map[1:0]); end
            end
        end
        checks++; if (cols_passed !== 16'd3) begin errors++; $display("FAIL scroll_cols got=%0d exp=3", cols_passed); end
    endtask

    task automatic test_gap_coding();
        for (int g = 0; g < 3; g++) begin
            int offset;
            int ticks_seen;
            int zeros_since;
            int guard;
            offset = $urandom_range(1, 37) + g * 11;
            clk_step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < offset; i++) clk_step(1'b1, 1'b0, 1'b0);
            clk_step(1'b1, 1'b1, 1'b0);
            ticks_seen = 0; zeros_since = 0; guard = 0;
            while (ticks_seen < 2000 && guard < 2000 * TD + 10) begin
                clk_step(1'b1, 1'b1, 1'b0);
                guard++;
                checks++; if (tick !== m_tick) begin errors++; $display("FAIL gap_tick game=%0d got=%b exp=%b", g, tick, m_tick); end
                checks++; if (map !== m_map) begin errors++; $display("FAIL gap_map game=%0d got=%h exp=%h", g, map, m_map); end
                checks++; if (dut.u_lfsr.state !== m_lfsr) begin errors++; $display("FAIL gap_lfsr game=%0d got=%h exp=%h", g, dut.u_lfsr.state, m_lfsr); end
                checks++; if (cols_passed !== m_cols) begin errors++; $display("FAIL gap_cols game=%0d got=%0d exp=%0d", g, cols_passed, m_cols); end
                if (m_tick) begin
                    ticks_seen++;
                    checks++; if (map[1:0] === 2'b11) begin errors++; $display("FAIL gap_code11 game=%0d tick=%0d got=11 exp=not11", g, ticks_seen); end
                    if (map[1:0] !== 2'b00) begin
                        checks++; if (zeros_since < MG) begin errors++; $display("FAIL gap_min game=%0d zeros=%0d exp>=%0d", g, zeros_since, MG); end
                        zeros_since = 0;
                    end else begin
                        zeros_since++;
                    end
                end
            end
            checks++; if (ticks_seen != 2000) begin errors++; $display("FAIL gap_budget game=%0d ticks=%0d exp=2000", g, ticks_seen); end
        end
    endtask

    task automatic test_death();
        logic [15:0] saved_map;
        logic [15:0] saved_cols;
        int guard;
        clk_step(1'b1, 1'b0, 1'b0);
        clk_step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 41; i++) clk_step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (((m_run + 1) % TD) != 0 && guard < 2 * TD) begin
            clk_step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        saved_map = m_map;
        saved_cols = m_cols;
        clk_step(1'b1, 1'b1, 1'b1);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL death_tick got=%b exp=0", tick); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL death_running got=%b exp=0", running); end
        checks++; if (map !== saved_map) begin errors++; $display("FAIL death_map got=%h exp=%h", map, saved_map); end
        for (int i = 0; i < 100; i++) begin
            clk_step(1'b1, 1'b1, 1'($urandom % 2));
            checks++; if (map !== saved_map || tick !== 1'b0 || cols_passed !== saved_cols) begin
                errors++; $display("FAIL death_hold cyc=%0d map=%h tick=%b cols=%0d exp map=%h tick=0 cols=%0d", i, map, tick, cols_passed, saved_map, saved_cols);
            end
        end
        clk_step(1'b1, 1'b0, 1'b0);
        checks++; if (map !== 16'h0000) begin errors++; $display("FAIL death_exit_map got=%h exp=0000", map); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL death_exit_running got=%b exp=0", running); end
    endtask

    task automatic test_abort();
        clk_step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9 + int'($urandom % 8); i++) clk_step(1'b1, 1'b1, 1'b0);
        checks++; if (cols_passed !== m_cols) begin errors++; $display("FAIL abort_pre_cols got=%0d exp=%0d", cols_passed, m_cols); end
        clk_step(1'b1, 1'b0, 1'b1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL abort_running got=%b exp=0", running); end
        checks++; if (cols_passed !== 16'h0000) begin errors++; $display("FAIL abort_cols got=%0d exp=0", cols_passed); end
        checks++; if (map !== 16'h0000) begin errors++; $display("FAIL abort_map got=%h exp=0000", map); end
        // from IDLE a start re-enters RUN at once; from DEAD it could not
        clk_step(1'b1, 1'b1, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL abort_was_idle got=%b exp=1", running); end
        checks++; if (dut.u_lfsr.state !== m_lfsr) begin errors++; $display("FAIL abort_lfsr got=%h exp=%h", dut.u_lfsr.state, m_lfsr); end
    endtask

    task automatic test_saturation();
        int guard;
        clk_step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while ((m_run % TD) != 1 && guard < 2 * TD) begin
            clk_step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        force dut.cols_passed = 16'hFFFE;
        #1;
        release dut.cols_passed;
        m_cols = 16'hFFFE;
        for (int i = 0; i < 3 * TD; i++) begin
            clk_step(1'b1, 1'b1, 1'b0);
            checks++; if (cols_passed !== m_cols) begin errors++; $display("FAIL sat_cols cyc=%0d got=%h exp=%h", i, cols_passed, m_cols); end
        end
        checks++; if (cols_passed !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h exp=ffff", cols_passed); end
    endtask

    initial begin
        m_st = 0; m_lfsr = SEED; m_map = '0; m_tick = 1'b0; m_cols = '0; m_run = 0; m_since = 0;
        test_reset();
        test_scroll_timing();
        test_gap_coding();
        test_death();
        test_abort();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_generator.md
MAP_GENERATOR -- requirements
Module: map_generator

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000, giving clk cycles per scroll step (4 Hz at 100 MHz).
REQ-002 SHALL have parameter MIN_GAP, default 2, giving the minimum number of empty columns after any obstacle column.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, giving the non-zero LFSR reset value.
REQ-004 clk  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  game-run level; 1 = play, 0 = return to idle.
REQ-007 is_dead  input  1  death flag from the physics stage; 1 freezes the scroll.
REQ-008 map  output  16  8 columns x 2 bits; map[15:14] = player column (col 0), map[1:0] = newest column (col 7).
REQ-009 tick  output  1  one-cycle pulse, high in the cycle map first shows a newly shifted value.
REQ-010 running  output  1  high while in RUN.
REQ-011 cols_passed  output  16  number of scroll steps taken this game.

Function
REQ-012 Column encoding SHALL be 00 = none, 01 = low block, 10 = high block; 11 SHALL never be emitted.
REQ-013 FSM states SHALL be IDLE, RUN and DEAD.
REQ-014 IDLE SHALL move to RUN when start=1.
REQ-015 RUN SHALL move to DEAD when is_dead=1 and start=1.
REQ-016 RUN or DEAD SHALL move to IDLE when start=0; start=0 SHALL take priority over is_dead.
REQ-017 DEAD SHALL leave only via start=0.
REQ-018 In IDLE: map=0, tick=0, divider=0, gap_cnt=0, cols_passed=0.
REQ-019 In IDLE the LFSR SHALL advance every clk, so each game's sequence depends on start timing.
REQ-020 In RUN the divider SHALL count 0..TICK_DIV-1; on the edge where it equals TICK_DIV-1, the divider SHALL wrap to 0, map SHALL load {map[13:0], new_col}, tick SHALL go to 1, and the LFSR SHALL advance one step.
REQ-021 First tick SHALL appear TICK_DIV cycles after entering RUN, with period TICK_DIV thereafter.
REQ-022 In RUN the LFSR SHALL advance only on tick edges.
REQ-023 new_col SHALL be 00 while gap_cnt < MIN_GAP, with gap_cnt incremented (saturating at MIN_GAP).
REQ-024 Otherwise new_col SHALL be taken from lfsr[1:0] (11 mapped to 00); a non-zero new_col SHALL reset gap_cnt to 0.
REQ-025 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0; a zero state SHALL reload LFSR_SEED.
REQ-026 cols_passed SHALL increment on each tick and saturate at 16'hFFFF.
REQ-027 If is_dead rises on the same edge as a pending tick, the tick SHALL be suppressed and map SHALL not shift.
REQ-028 In DEAD, map and cols_passed SHALL hold and tick SHALL stay 0.
REQ-029 TICK_DIV SHALL be >= 2; divider width SHALL be $clog2(TICK_DIV).

Reset
REQ-030 With rst_n=0 at a clk edge: state=IDLE, map=0, tick=0, running=0, cols_passed=0, divider=0, gap_cnt=0, lfsr=LFSR_SEED.
REQ-031 Reset SHALL override all inputs, including mid-game.
REQ-032 After reset release with start=1, RUN SHALL be entered one cycle later.

Structure
REQ-033 Shared package ue_pkg SHALL hold the obstacle codes (OBS_NONE, OBS_LOW, OBS_HIGH), the FSM state enum, and the LFSR tap constant; the physics stage SHALL use the same codes.
REQ-034 One sub-module, lfsr16 (ports: clk, rst_n, advance, state[15:0]), SHALL hold the LFSR; all other logic SHALL be in map_generator.

Verification (TICK_DIV=4, MIN_GAP=2 unless noted)
REQ-035 Reset: rst_n=0 for 2 cycles -> map=0, tick=0, running=0, cols_passed=0, lfsr=16'hACE1.
REQ-036 Scroll timing: release reset, start=1 -> running=1 next cycle; tick at RUN cycles 4, 8, 12; first two new columns 00; cols_passed=3 after the third tick.
REQ-037 Gap and coding: run 2000 ticks from 3 different start offsets -> never 11; every non-zero column is followed by at least 2 columns of 00; model-checked LFSR sequence matches.
REQ-038 Death: is_dead=1 on the cycle a tick is due -> no tick; map stable for 100 cycles; start=0 -> map=0 and running=0 on the next cycle.
REQ-039 Abort: start=0 mid-RUN with is_dead=1 simultaneously -> IDLE next cycle (not DEAD), cols_passed=0.
REQ-040 Saturation: force cols_passed=16'hFFFE, 3 ticks -> value holds at 16'hFFFF.
